// File: rtl/grn_job_ctrl_if.sv
// ============================================================================
// Module  : grn_job_ctrl_if
// Brief   : Job-control, read-channel and status-write signal bundle.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface grn_job_ctrl_if #(
    parameter int ADDR_W = 42
);
    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [31:0]       num_lines;
    logic [ADDR_W-1:0] dsm_base;
    logic              c0_almost_full;
    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_rsp_valid;
    logic              c1_almost_full;
    logic              wr_req_valid;
    logic [ADDR_W-1:0] wr_req_addr;
    logic [63:0]       wr_req_data;
    logic              wr_rsp_valid;
    logic              busy;
    logic              done;
    logic [31:0]       lines_received;

    // Controller side: issues reads and the status write.
    modport master (
        input  start, src_base, num_lines, dsm_base,
        input  c0_almost_full, rd_rsp_valid, c1_almost_full, wr_rsp_valid,
        output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
        output busy, done, lines_received
    );

    // CSR / memory side.
    modport slave (
        output start, src_base, num_lines, dsm_base,
        output c0_almost_full, rd_rsp_valid, c1_almost_full, wr_rsp_valid,
        input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data,
        input  busy, done, lines_received
    );
endinterface

`default_nettype wire

// File: rtl/grn_job_ctrl.sv
// ============================================================================
// Module  : grn_job_ctrl
// Brief   : Streams num_lines cache-line reads, then writes a DSM status word.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module grn_job_ctrl #(
    parameter int ADDR_W          = 42,
    parameter int MAX_OUTSTANDING = 64
) (
    input  wire logic    clk,
    input  wire logic    reset,
    grn_job_ctrl_if.master bus
);
    localparam int c_out_w = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUTSTANDING);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_issue   = 3'd1;
    localparam logic [2:0] c_st_drain   = 3'd2;
    localparam logic [2:0] c_st_status  = 3'd3;
    localparam logic [2:0] c_st_wait_wr = 3'd4;

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_src_base;
    logic [ADDR_W-1:0]  r_dsm_base;
    logic [31:0]        r_num_lines;
    logic [31:0]        r_issued;
    logic [31:0]        r_received;
    logic [c_out_w-1:0] r_outstanding;
    logic               r_rd_req_valid;
    logic [ADDR_W-1:0]  r_rd_req_addr;
    logic               r_wr_req_valid;
    logic [ADDR_W-1:0]  r_wr_req_addr;
    logic [63:0]        r_wr_req_data;
    logic               r_busy;
    logic               r_done;

    logic               w_issue;
    logic               w_rsp;
    logic               w_wr_fire;
    logic [31:0]        w_issued_nxt;
    logic [31:0]        w_received_nxt;
    logic [2:0]         w_state_nxt;

    always_comb begin
        w_issue = (r_state == c_st_issue) && !bus.c0_almost_full &&
                  (r_outstanding < c_max_out) && (r_issued != r_num_lines);
        // Completions only count while a job is actually collecting data.
        w_rsp   = bus.rd_rsp_valid &&
                  ((r_state == c_st_issue) || (r_state == c_st_drain));
        w_wr_fire      = (r_state == c_st_status) && !bus.c1_almost_full;
        w_issued_nxt   = r_issued + {31'b0, w_issue};
        w_received_nxt = r_received + {31'b0, w_rsp};

        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:
                if (bus.start)
                    w_state_nxt = (bus.num_lines != 32'd0) ? c_st_issue : c_st_status;
            c_st_issue:
                if (w_issued_nxt == r_num_lines)
                    w_state_nxt = (w_received_nxt == r_num_lines) ? c_st_status : c_st_drain;
            c_st_drain:
                if (w_received_nxt == r_num_lines)
                    w_state_nxt = c_st_status;
            c_st_status:
                if (w_wr_fire)
                    w_state_nxt = c_st_wait_wr;
            c_st_wait_wr:
                if (bus.wr_rsp_valid)
                    w_state_nxt = c_st_idle;
            default:
                w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_src_base     <= '0;
            r_dsm_base     <= '0;
            r_num_lines    <= '0;
            r_issued       <= '0;
            r_received     <= '0;
            r_outstanding  <= '0;
            r_rd_req_valid <= 1'b0;
            r_rd_req_addr  <= '0;
            r_wr_req_valid <= 1'b0;
            r_wr_req_addr  <= '0;
            r_wr_req_data  <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_busy         <= (w_state_nxt != c_st_idle);
            r_done         <= (r_state == c_st_wait_wr) && bus.wr_rsp_valid;
            r_rd_req_valid <= w_issue;
            r_wr_req_valid <= w_wr_fire;

            if (w_issue)
                r_rd_req_addr <= r_src_base + ADDR_W'(r_issued);

            if (w_wr_fire) begin
                r_wr_req_addr <= r_dsm_base;
                r_wr_req_data <= {r_received, 31'b0, 1'b1};
            end

            if ((r_state == c_st_idle) && bus.start) begin
                r_src_base    <= bus.src_base;
                r_dsm_base    <= bus.dsm_base;
                r_num_lines   <= bus.num_lines;
                r_issued      <= '0;
                r_received    <= '0;
                r_outstanding <= '0;
            end else begin
                r_issued   <= w_issued_nxt;
                r_received <= w_received_nxt;
                case ({w_issue, w_rsp})
                    2'b10:   r_outstanding <= r_outstanding + 1'b1;
                    2'b01:   if (r_outstanding != '0) r_outstanding <= r_outstanding - 1'b1;
                    default: r_outstanding <= r_outstanding;
                endcase
            end
        end
    end

    assign bus.rd_req_valid   = r_rd_req_valid;
    assign bus.rd_req_addr    = r_rd_req_addr;
    assign bus.wr_req_valid   = r_wr_req_valid;
    assign bus.wr_req_addr    = r_wr_req_addr;
    assign bus.wr_req_data    = r_wr_req_data;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.lines_received = r_received;

endmodule

`default_nettype wire

// File: tb/tb_grn_job_ctrl.sv
// ============================================================================
// Module  : tb_grn_job_ctrl
// Brief   : Scoreboard bench for grn_job_ctrl with a delayed-response memory model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grn_job_ctrl;
    localparam int ADDR_W  = 42;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    grn_job_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    grn_job_ctrl #(.ADDR_W(ADDR_W), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int reads, writes, done_count, tb_out, max_out, rd_cyc_first, rd_cyc_last;
    logic done_busy;
    logic [ADDR_W-1:0] exp_rd[$];
    logic [ADDR_W-1:0] exp_wr_addr[$];
    logic [63:0]       exp_wr_data[$];
    logic [ADDR_W-1:0] m_addr;
    logic [63:0]       m_data;
    int  pend_due[$];
    int  wr_due;
    bit  wr_pend;
    bit  rsp_hold;
    int  rsp_release;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard: every observed request is checked against the queues.
    initial begin
        reads = 0; writes = 0; done_count = 0; tb_out = 0; max_out = 0;
        rd_cyc_first = 0; rd_cyc_last = 0; done_busy = 1'b0; wr_pend = 0; wr_due = 0;
        forever begin
            @(negedge clk);
            if (bus.rd_req_valid === 1'b1) begin
                reads++;
                if (reads == 1) rd_cyc_first = cyc;
                rd_cyc_last = cyc;
                pend_due.push_back(cyc + 3);
                tb_out++;
                if (tb_out > max_out) max_out = tb_out;
                checks++;
                if (exp_rd.size() == 0) begin
                    errors++;
                    $display("FAIL rd_addr: unexpected read at %0h, none expected", bus.rd_req_addr);
                end else begin
                    m_addr = exp_rd.pop_front();
                    if (bus.rd_req_addr !== m_addr) begin
                        errors++;
                        $display("FAIL rd_addr: got %0h expected %0h", bus.rd_req_addr, m_addr);
                    end
                end
            end
            if (bus.wr_req_valid === 1'b1) begin
                writes++;
                wr_pend = 1;
                wr_due  = cyc + 2;
                checks++;
                if (exp_wr_addr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_req: unexpected write addr %0h data %0h", bus.wr_req_addr, bus.wr_req_data);
                end else begin
                    m_addr = exp_wr_addr.pop_front();
                    m_data = exp_wr_data.pop_front();
                    if (bus.wr_req_addr !== m_addr || bus.wr_req_data !== m_data) begin
                        errors++;
                        $display("FAIL wr_req: got addr %0h data %0h expected addr %0h data %0h",
                                 bus.wr_req_addr, bus.wr_req_data, m_addr, m_data);
                    end
                end
            end
            if (bus.done === 1'b1) begin
                done_count++;
                done_busy = bus.busy;
            end
        end
    end

    // Memory model: one read completion per cycle, three cycles after each request.
    initial begin
        bus.rd_rsp_valid = 1'b0;
        bus.wr_rsp_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rd_rsp_valid = 1'b0;
            if (pend_due.size() > 0 && pend_due[0] <= cyc && (!rsp_hold || rsp_release > 0)) begin
                bus.rd_rsp_valid = 1'b1;
                void'(pend_due.pop_front());
                tb_out--;
                if (rsp_hold) rsp_release--;
            end
            bus.wr_rsp_valid = 1'b0;
            if (wr_pend && wr_due <= cyc) begin
                bus.wr_rsp_valid = 1'b1;
                wr_pend = 0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_job(input logic [ADDR_W-1:0] src, input logic [31:0] n,
                             input logic [ADDR_W-1:0] dsm);
        @(posedge clk); #1;
        bus.src_base  = src;
        bus.num_lines = n;
        bus.dsm_base  = dsm;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    task automatic clear_stats();
        reads = 0; writes = 0; max_out = 0;
    endtask

    task automatic wait_done(input int d0);
        for (int k = 0; k < 400 && done_count == d0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1; bus.num_lines = 32'd5; bus.src_base = '0; bus.dsm_base = '0;
        bus.c0_almost_full = 1'b0; bus.c1_almost_full = 1'b0;
        rsp_hold = 0; rsp_release = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
        checks++; if (bus.rd_req_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b expected 0", bus.rd_req_valid); end
        checks++; if (bus.wr_req_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %0b expected 0", bus.wr_req_valid); end
        checks++; if (bus.rd_req_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0h expected 0", bus.rd_req_addr); end
        checks++; if (bus.wr_req_addr !== '0 || bus.wr_req_data !== 64'h0) begin errors++; $display("FAIL reset_wr_bus: got %0h/%0h expected 0/0", bus.wr_req_addr, bus.wr_req_data); end
        checks++; if (bus.lines_received !== 32'd0) begin errors++; $display("FAIL reset_lines: got %0d expected 0", bus.lines_received); end
        @(posedge clk); #1;
        reset = 1'b0; bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_start_precedence: busy got %0b expected 0", bus.busy); end
    endtask

    task automatic test_basic();
        int d0;
        clear_stats();
        d0 = done_count;
        for (int i = 0; i < 4; i++) exp_rd.push_back(42'h100 + ADDR_W'(i));
        exp_wr_addr.push_back(42'h5000);
        exp_wr_data.push_back(64'h0000_0004_0000_0001);
        start_job(42'h100, 32'd4, 42'h5000);
        wait_done(d0);
        checks++; if (done_count != d0 + 1) begin errors++; $display("FAIL basic_done: got %0d pulses expected 1", done_count - d0); end
        checks++; if (reads != 4) begin errors++; $display("FAIL basic_reads: got %0d expected 4", reads); end
        checks++; if (rd_cyc_last - rd_cyc_first != 3) begin errors++; $display("FAIL basic_back_to_back: span got %0d expected 3", rd_cyc_last - rd_cyc_first); end
        checks++; if (writes != 1) begin errors++; $display("FAIL basic_writes: got %0d expected 1", writes); end
        checks++; if (bus.lines_received !== 32'd4) begin errors++; $display("FAIL basic_lines: got %0d expected 4", bus.lines_received); end
        checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done: got %0b expected 0", done_busy); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %0b expected 0", bus.busy); end
    endtask

    task automatic test_zero_len();
        int d0;
        clear_stats();
        d0 = done_count;
        exp_wr_addr.push_back(42'h77);
        exp_wr_data.push_back(64'h1);
        start_job(42'h300, 32'd0, 42'h77);
        wait_done(d0);
        checks++; if (done_count != d0 + 1) begin errors++; $display("FAIL zero_done: got %0d pulses expected 1", done_count - d0); end
        checks++; if (reads != 0) begin errors++; $display("FAIL zero_reads: got %0d expected 0", reads); end
        checks++; if (writes != 1) begin errors++; $display("FAIL zero_writes: got %0d expected 1", writes); end
    endtask

    task automatic test_outstanding();
        int d0;
        clear_stats();
        d0 = done_count;
        rsp_hold = 1; rsp_release = 0;
        for (int i = 0; i < 10; i++) exp_rd.push_back(42'h1000 + ADDR_W'(i));
        exp_wr_addr.push_back(42'h7000);
        exp_wr_data.push_back(64'h0000_000A_0000_0001);
        start_job(42'h1000, 32'd10, 42'h7000);
        repeat (20) @(negedge clk);
        checks++; if (reads != 4) begin errors++; $display("FAIL outst_limit: got %0d reads expected 4", reads); end
        rsp_release = 1;
        repeat (8) @(negedge clk);
        checks++; if (reads != 5) begin errors++; $display("FAIL outst_resume1: got %0d reads expected 5", reads); end
        rsp_release = 2;
        repeat (8) @(negedge clk);
        checks++; if (reads != 7) begin errors++; $display("FAIL outst_resume2: got %0d reads expected 7", reads); end
        rsp_hold = 0;
        wait_done(d0);
        checks++; if (done_count != d0 + 1) begin errors++; $display("FAIL outst_done: got %0d pulses expected 1", done_count - d0); end
        checks++; if (reads != 10 || max_out != 4) begin errors++; $display("FAIL outst_total: got %0d reads max %0d expected 10 max 4", reads, max_out); end
        checks++; if (bus.lines_received !== 32'd10) begin errors++; $display("FAIL outst_lines: got %0d expected 10", bus.lines_received); end
    endtask

    task automatic test_backpressure();
        int d0;
        clear_stats();
        d0 = done_count;
        bus.c1_almost_full = 1'b1;
        for (int i = 0; i < 8; i++) exp_rd.push_back(42'h2000 + ADDR_W'(i));
        exp_wr_addr.push_back(42'h6000);
        exp_wr_data.push_back(64'h0000_0008_0000_0001);
        start_job(42'h2000, 32'd8, 42'h6000);
        for (int k = 0; k < 60 && reads < 3; k++) @(negedge clk);
        @(posedge clk); #1;
        bus.c0_almost_full = 1'b1;
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            checks++; if (bus.rd_req_valid !== 1'b0) begin errors++; $display("FAIL c0_hold: rd_req_valid got %0b expected 0", bus.rd_req_valid); end
            @(posedge clk);
        end
        #1 bus.c0_almost_full = 1'b0;
        for (int k = 0; k < 200 && bus.lines_received != 32'd8; k++) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            checks++; if (bus.wr_req_valid !== 1'b0) begin errors++; $display("FAIL c1_hold: wr_req_valid got %0b expected 0", bus.wr_req_valid); end
        end
        checks++; if (bus.busy !== 1'b1 || writes != 0) begin errors++; $display("FAIL c1_status_wait: busy %0b writes %0d expected 1 and 0", bus.busy, writes); end
        @(posedge clk); #1;
        bus.c1_almost_full = 1'b0;
        wait_done(d0);
        checks++; if (done_count != d0 + 1) begin errors++; $display("FAIL bp_done: got %0d pulses expected 1", done_count - d0); end
        checks++; if (reads != 8 || exp_rd.size() != 0) begin errors++; $display("FAIL bp_reads: got %0d reads, %0d missing, expected 8 and 0", reads, exp_rd.size()); end
        checks++; if (writes != 1) begin errors++; $display("FAIL bp_writes: got %0d expected 1", writes); end
    endtask

    task automatic test_wrap();
        int d0;
        clear_stats();
        d0 = done_count;
        exp_rd.push_back(42'h3FF_FFFF_FFFE);
        exp_rd.push_back(42'h3FF_FFFF_FFFF);
        exp_rd.push_back(42'h0);
        exp_wr_addr.push_back(42'h10);
        exp_wr_data.push_back(64'h0000_0003_0000_0001);
        start_job(42'h3FF_FFFF_FFFE, 32'd3, 42'h10);
        wait_done(d0);
        checks++; if (done_count != d0 + 1 || reads != 3) begin errors++; $display("FAIL wrap_job: got %0d pulses %0d reads expected 1 and 3", done_count - d0, reads); end
    endtask

    task automatic test_abort();
        int d0, w0;
        // Start pulsed during DRAIN must not disturb the running job.
        clear_stats();
        d0 = done_count;
        for (int i = 0; i < 6; i++) exp_rd.push_back(42'h4000 + ADDR_W'(i));
        exp_wr_addr.push_back(42'h8000);
        exp_wr_data.push_back(64'h0000_0006_0000_0001);
        start_job(42'h4000, 32'd6, 42'h8000);
        for (int k = 0; k < 100 && reads < 6; k++) @(negedge clk);
        start_job(42'hDEAD, 32'd2, 42'h9999);
        wait_done(d0);
        checks++; if (done_count != d0 + 1 || reads != 6 || writes != 1) begin errors++; $display("FAIL drain_start: got %0d pulses %0d reads %0d writes expected 1/6/1", done_count - d0, reads, writes); end
        checks++; if (bus.lines_received !== 32'd6) begin errors++; $display("FAIL drain_lines: got %0d expected 6", bus.lines_received); end

        // Reset mid-ISSUE abandons the job; late completions are ignored.
        clear_stats();
        for (int i = 0; i < 20; i++) exp_rd.push_back(42'h5000 + ADDR_W'(i));
        start_job(42'h5000, 32'd20, 42'hA000);
        for (int k = 0; k < 100 && reads < 5; k++) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_rd.delete();
        d0 = done_count;
        w0 = writes;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b expected 0", bus.busy); end
        repeat (20) @(negedge clk);
        checks++; if (done_count != d0 || writes != w0) begin errors++; $display("FAIL abort_quiet: got %0d pulses %0d writes expected 0 and 0", done_count - d0, writes - w0); end
        checks++; if (bus.lines_received !== 32'd0) begin errors++; $display("FAIL abort_late_rsp: lines got %0d expected 0", bus.lines_received); end

        clear_stats();
        d0 = done_count;
        for (int i = 0; i < 3; i++) exp_rd.push_back(42'h40 + ADDR_W'(i));
        exp_wr_addr.push_back(42'hB000);
        exp_wr_data.push_back(64'h0000_0003_0000_0001);
        start_job(42'h40, 32'd3, 42'hB000);
        wait_done(d0);
        checks++; if (done_count != d0 + 1 || reads != 3 || writes != 1) begin errors++; $display("FAIL post_reset_job: got %0d pulses %0d reads %0d writes expected 1/3/1", done_count - d0, reads, writes); end
        checks++; if (bus.lines_received !== 32'd3) begin errors++; $display("FAIL post_reset_lines: got %0d expected 3", bus.lines_received); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_outstanding();
        test_backpressure();
        test_wrap();
        test_abort();
        checks++;
        if (exp_wr_addr.size() != 0) begin errors++; $display("FAIL leftover_writes: got %0d pending expected 0", exp_wr_addr.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/grn_job_ctrl.md
GRN_JOB_CTRL -- requirements
Module: grn_job_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 42, meaning cache-line address width.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 64, meaning the maximum number of in-flight reads (power of two, at most 256).
REQ-003 SHALL have port clk, input, width 1, the single rising-edge clock.
REQ-004 SHALL have port reset, input, width 1, a synchronous active-high reset.
REQ-005 SHALL have port start, input, width 1, a one-cycle job start pulse from the CSR block.
REQ-006 SHALL have port src_base, input, width ADDR_W, the source buffer cache-line address.
REQ-007 SHALL have port num_lines, input, width 32, the job length in cache lines.
REQ-008 SHALL have port dsm_base, input, width ADDR_W, the status (DSM) cache-line address.
REQ-009 SHALL have port c0_almost_full, input, width 1, read-channel backpressure.
REQ-010 SHALL have port rd_req_valid, output, width 1, the read request strobe.
REQ-011 SHALL have port rd_req_addr, output, width ADDR_W, the read request line address.
REQ-012 SHALL have port rd_rsp_valid, input, width 1, one read completion per cycle when high.
REQ-013 SHALL have port c1_almost_full, input, width 1, write-channel backpressure.
REQ-014 SHALL have port wr_req_valid, output, width 1, the status write strobe.
REQ-015 SHALL have port wr_req_addr, output, width ADDR_W, the status write address.
REQ-016 SHALL have port wr_req_data, output, width 64, the status word.
REQ-017 SHALL have port wr_rsp_valid, input, width 1, the status write completion.
REQ-018 SHALL have port busy, output, width 1, high whenever the FSM is not in IDLE.
REQ-019 SHALL have port done, output, width 1, a one-cycle job completion pulse.
REQ-020 SHALL have port lines_received, output, width 32, the count of responses received in the current or last job.

Function
REQ-021 SHALL implement FSM states IDLE, ISSUE, DRAIN, STATUS and WAIT_WR, with all outputs registered.
REQ-022 In IDLE, when start=1, SHALL latch src_base, num_lines and dsm_base, and clear the issued count, the received count and lines_received.
REQ-023 On that start, SHALL go to ISSUE if num_lines!=0, else to STATUS.
REQ-024 In ISSUE, SHALL issue a read in a given cycle iff c0_almost_full=0 and outstanding<MAX_OUTSTANDING.
REQ-025 For each issued read, the next cycle SHALL show rd_req_valid=1 and rd_req_addr=(src_base+issued) mod 2^ADDR_W; otherwise rd_req_valid=0 next cycle.
REQ-026 SHALL move from ISSUE to DRAIN on the cycle the issued count reaches num_lines; no read SHALL be issued beyond num_lines.
REQ-027 SHALL update outstanding as +1 per issue and -1 per rd_rsp_valid; a simultaneous issue and response SHALL leave it unchanged.
REQ-028 SHALL increment the received count on each rd_rsp_valid in ISSUE or DRAIN, and SHALL ignore rd_rsp_valid in IDLE, STATUS and WAIT_WR.
REQ-029 SHALL move from DRAIN to STATUS when the received count equals num_lines, including when the final response arrives in the same cycle as the last issue.
REQ-030 In STATUS, when c1_almost_full=0, the next cycle SHALL show a single wr_req_valid=1 with wr_req_addr=dsm_base and wr_req_data={received[31:0], 31'b0, 1'b1}, and the FSM SHALL go to WAIT_WR.
REQ-031 While c1_almost_full=1, the FSM SHALL stay in STATUS with wr_req_valid=0.
REQ-032 In WAIT_WR, on wr_rsp_valid, SHALL pulse done=1 for exactly one cycle, return to IDLE and clear busy in that same cycle.
REQ-033 SHALL ignore start in any state other than IDLE; latched parameters SHALL not change mid-job.
REQ-034 SHALL hold lines_received equal to the received count, retained in IDLE until the next start.
REQ-035 SHALL have a read latency from an issue decision to rd_req_valid of exactly 1 cycle.
REQ-036 SHALL sustain a peak of one read per cycle.

Reset
REQ-037 When reset=1, SHALL go to IDLE and zero all counters, rd_req_valid, wr_req_valid, done, busy, rd_req_addr, wr_req_addr, wr_req_data and lines_received.
REQ-038 Reset SHALL take precedence over start and all responses.
REQ-039 Reset mid-job SHALL abandon the job with no status write.
REQ-040 Responses arriving after reset SHALL be ignored.

Verification
REQ-041 SHALL cover: src_base=0x100, num_lines=4, no backpressure, responses 3 cycles after each request -> rd_req_addr 0x100..0x103 on consecutive cycles, one status write to dsm_base with data 0x0000_0004_0000_0001, then one done pulse.
REQ-042 SHALL cover: num_lines=0 -> no reads, status write with data 0x1, and a done pulse.
REQ-043 SHALL cover: MAX_OUTSTANDING=4, num_lines=10, responses withheld -> exactly 4 reads issued, then issue resumes one read per response.
REQ-044 SHALL cover: c0_almost_full held high for 5 cycles mid-issue, then c1_almost_full held high in STATUS -> no rd_req_valid or wr_req_valid while held, and no lost or duplicated addresses.
REQ-045 SHALL cover: src_base=2^42-2, num_lines=3 -> addresses 2^42-2, 2^42-1 and 0.
REQ-046 SHALL cover: start pulsed in DRAIN and reset asserted mid-ISSUE -> the start is ignored, and after reset busy=0, done never pulses and the next job runs cleanly.
